// File: rtl/i2s_dac_transmitter.sv
// i2s_dac_transmitter: mono Philips I2S serializer for the on-dock audio DAC, with amplifier enable.
// Ports: clk/rst (sync active-high), enable (0 behaves as reset), sound (signed PCM sample, latched once per frame),
//        sample_req (one-clk pulse when sound is latched), bclk/lrclk/sdata (I2S, MSB first, 32-bit slots), pa_en.
module i2s_dac_transmitter #(
    parameter int clk_mhz        = 27,
    parameter int sample_rate_hz = 52734,
    parameter int w_sample       = 16,
    parameter int half_period    = (clk_mhz * 1000000 / (sample_rate_hz * 128)) > 1
                                   ? clk_mhz * 1000000 / (sample_rate_hz * 128) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [w_sample-1:0] sound,
    output logic                sample_req,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                pa_en
);
    localparam int dw = half_period > 1 ? $clog2(half_period) : 1;
    logic [dw-1:0]       div_q, div_d;
    logic [5:0]          bit_idx_q, bit_idx_d, idx_n;
    logic [w_sample-1:0] latched_q, latched_d, shifted;
    logic                bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic                req_q, req_d, pa_en_q, pa_en_d, started_q, started_d;
    logic                tick, fall;
    always_comb begin
        tick      = div_q == dw'(half_period - 1);
        fall      = tick && bclk_q;
        // the first fall after reset presents bit 0 rather than advancing
        idx_n     = started_q ? bit_idx_q + 6'd1 : 6'd0;
        // slot bit s carries latched[w-s] for s in 1..w; s=0 and s>w shift everything out to 0
        shifted   = latched_q << (idx_n[4:0] - 5'd1);
        div_d     = tick ? '0 : div_q + 1'b1;
        bclk_d    = bclk_q ^ tick;
        bit_idx_d = fall ? idx_n : bit_idx_q;
        started_d = started_q | fall;
        lrclk_d   = fall ? idx_n[5] : lrclk_q;
        sdata_d   = fall ? shifted[w_sample-1] : sdata_q;
        req_d     = fall && idx_n == 6'd0;
        latched_d = req_d ? sound : latched_q;
        pa_en_d   = pa_en_q | (fall && started_q && idx_n == 6'd0);
    end
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div_q     <= '0;
            bit_idx_q <= '0;
            latched_q <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            req_q     <= 1'b0;
            pa_en_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            latched_q <= latched_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            req_q     <= req_d;
            pa_en_q   <= pa_en_d;
            started_q <= started_d;
        end
    end
    assign bclk       = bclk_q;
    assign lrclk      = lrclk_q;
    assign sdata      = sdata_q;
    assign sample_req = req_q;
    assign pa_en      = pa_en_q;
endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// tb_i2s_dac_transmitter: randomized check of both divider settings against a closed-form frame model.
module tb_i2s_dac_transmitter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        en0 = 1'b0, en1 = 1'b0;
    logic [15:0] snd0 = '0, snd1 = '0;
    logic        req0, bclk0, lr0, sd0, pa0;
    logic        req1, bclk1, lr1, sd1, pa1;
    int          vectors = 0, errors = 0;
    int          k = -1;
    logic [15:0] cur_smp = '0;
    logic        sel = 1'b0;

    i2s_dac_transmitter dut (
        .clk(clk), .rst(rst), .enable(en0), .sound(snd0), .sample_req(req0),
        .bclk(bclk0), .lrclk(lr0), .sdata(sd0), .pa_en(pa0)
    );
    i2s_dac_transmitter #(.half_period(1)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .sound(snd1), .sample_req(req1),
        .bclk(bclk1), .lrclk(lr1), .sdata(sd1), .pa_en(pa1)
    );

    always #5 clk = ~clk;

    // Outputs after the k-th enabled edge: {bclk, lrclk, sdata, sample_req, pa_en}.
    function automatic logic [4:0] model(input int kk, input int h, input logic [15:0] smp);
        int n, f, p, s;
        logic b, lr, sd, rq, pa;
        if (kk < 0) return 5'b0;
        n = (kk + 1) / h;
        b = (n % 2) == 1;
        f = n / 2;
        if (f == 0) return {b, 4'b0};
        p  = f - 1;
        s  = p % 32;
        lr = ((p / 32) % 2) == 1;
        sd = (s >= 1 && s <= 16) ? smp[16 - s] : 1'b0;
        rq = ((kk + 1) % h == 0) && !b && (p % 64 == 0);
        pa = p >= 64;
        return {b, lr, sd, rq, pa};
    endfunction

    task automatic tick(input string tag);
        logic [4:0] exp_v, obs;
        logic e;
        logic [15:0] sn;
        int h;
        @(posedge clk);
        e  = sel ? en1 : en0;
        sn = sel ? snd1 : snd0;
        h  = sel ? 1 : 4;
        k  = (rst || !e) ? -1 : k + 1;
        exp_v = model(k, h, cur_smp);
        if (exp_v[1]) begin
            cur_smp = sn;
            exp_v = model(k, h, cur_smp);
        end
        @(negedge clk);
        obs = sel ? {bclk1, lr1, sd1, req1, pa1} : {bclk0, lr0, sd0, req0, pa0};
        vectors++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s k=%0d got {bclk,lrclk,sdata,req,pa_en}=%b expected %b", tag, k, obs, exp_v);
        end
    endtask

    task automatic set_en(input logic v);
        if (sel) en1 = v; else en0 = v;
    endtask

    task automatic set_snd(input logic [15:0] v);
        if (sel) snd1 = v; else snd0 = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en0 = 1'b1;
        repeat (4) tick("reset");
        rst = 1'b0;
    endtask

    task automatic test_pattern();
        set_snd(16'hA5C3);
        repeat (1100) tick("pattern_a5c3");
    endtask

    task automatic test_sample_hold();
        set_snd(16'h7FFF);
        set_en(1'b0);
        tick("hold_disable");
        set_en(1'b1);
        repeat (200) tick("hold_7fff");
        set_snd(16'h8000);
        repeat (900) tick("hold_8000");
    endtask

    task automatic test_random();
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) set_snd(16'($urandom));
            tick("random");
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick("mid_reset_pre");
        rst = 1'b0;
        set_snd(16'h5AA5);
        repeat (7 + 8 * 20) tick("mid_reset_run");
        rst = 1'b1;
        tick("mid_reset_pulse");
        rst = 1'b0;
        repeat (700) begin
            if ($urandom_range(0, 15) == 0) set_snd(16'($urandom));
            tick("mid_reset_restart");
        end
    endtask

    task automatic test_enable_drop();
        repeat (300) tick("endrop_run");
        set_en(1'b0);
        repeat (3) tick("endrop_low");
        set_en(1'b1);
        repeat (600) tick("endrop_restart");
    endtask

    task automatic test_half1();
        en0 = 1'b0;
        tick("half1_switch");
        sel = 1'b1;
        en1 = 1'b0;
        tick("half1_idle");
        set_snd(16'h0001);
        set_en(1'b1);
        repeat (3 * 128 + 20) tick("half1_0001");
        repeat (600) begin
            if ($urandom_range(0, 5) == 0) set_snd(16'($urandom));
            tick("half1_random");
        end
        set_en(1'b0);
        repeat (2) tick("half1_disable");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_pattern();
        test_sample_hold();
        test_random();
        test_mid_reset();
        test_enable_drop();
        test_half1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/i2s_dac_transmitter.md
Name: i2s_dac_transmitter

Overview:
Serializes the 16-bit signed `sound` sample from lab_top into a standard Philips I2S stream for the board's on-dock audio DAC, and drives the amplifier enable. It sits directly downstream of lab_top's `sound` output, in the board-top sound-output path, with its outputs wired to HP_BCK, HP_WS, HP_DIN and PA_EN. It is mono: the same latched sample goes to the left and right slots. All outputs come from registers; no derived clocks are created.

Parameters:
clk_mhz, 27, system clock frequency in MHz.
sample_rate_hz, 52734, target frame rate. The actual rate is set by the integer divider below.
w_sample, 16, sample width. The slot width is fixed at 32 bits, so a frame is 64 bclk periods.
half_period, max(1, clk_mhz*1000000/(sample_rate_hz*128)), bclk half-period in clk cycles. Integer truncation. The default is 4, giving bclk = 3.375 MHz and fs = 52734 Hz.

Ports:
clk  input  1  system clock. The board top's clk, which is the same clock lab_top uses.
rst  input  1  synchronous, active-high reset.
enable  input  1  1 = run; 0 = return to the idle/reset state on the next cycle.
sound  input  w_sample  signed PCM sample, two's complement, sampled only at the latch point.
sample_req  output  1  one-clk pulse on the cycle `sound` is latched. The producer may update `sound` after this pulse.
bclk  output  1  I2S bit clock.
lrclk  output  1  word select: 0 = left slot, 1 = right slot.
sdata  output  1  serial data, MSB first.
pa_en  output  1  amplifier enable.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Reset is also applied whenever enable = 0.
- Reset values: bclk=0, lrclk=0, sdata=0, sample_req=0, pa_en=0, div_cnt=0, bit_idx=0, shift/latch registers=0.
- Divider:
  - div_cnt counts 0..half_period-1 and wraps to 0.
  - At div_cnt == half_period-1, bclk toggles on the next edge.
  - Rise event = the toggle 0->1; fall event = the toggle 1->0.
- Bit position:
  - bit_idx is 6 bits, range 0..63.
  - It advances on every fall event and wraps 63 -> 0.
  - All data-side outputs (lrclk, sdata) change only in the same cycle bclk falls. They are stable across the rise, where the DAC samples them.
- Frame layout, with s = bit_idx[4:0] (slot position):
  - lrclk = bit_idx[5] for the bit period being presented.
  - s == 0: sdata = 0. This is the I2S one-bit delay; the LSB of the previous slot is never emitted because the slot is padded.
  - s in 1..16: sdata = latched[16-s], so the MSB is at s=1 and the LSB at s=16.
  - s in 17..31: sdata = 0.
- Latch:
  - On the fall event where bit_idx becomes 0, `sound` is copied to latched.
  - sample_req = 1 for exactly that one clk cycle.
  - The right slot (bit_idx 32..63) reuses the same latched value, with no second latch.
- First frame after reset/enable:
  - bclk begins toggling half_period cycles after enable is sampled high.
  - The first fall event is treated as bit_idx 0. It latches and pulses sample_req.
- pa_en rises on the cycle bit_idx wraps 63 -> 0 for the first time after reset, i.e. after one full padded frame of zeros/valid data. It stays 1 until reset or enable = 0.
- Mid-frame reset or enable drop: the partial frame is abandoned. All outputs take reset values on the next edge. There is no glitch protection beyond that, and the DAC tolerates the truncated frame.
- `sound` changes at any time other than the latch cycle have no effect on the current frame.
- half_period = 1 is legal: bclk = clk/2, with a fall event every 2 cycles.

Test Plan:
1. half_period=4, enable=1 after reset, sound=16'hA5C3 held -> bclk period 8 clk. Left slot on sdata, bits s=0..16: 0,1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. Bits s=17..31 = 0. Right slot identical with lrclk=1.
2. Frame timing -> sample_req pulses exactly once per 512 clk (64 bclk × 8). It is a single cycle each time, coincident with the bclk fall that starts bit_idx 0. lrclk toggles every 256 clk.
3. sound changes from 16'h7FFF to 16'h8000 in the middle of the left slot -> the current frame (left and right) emits 7FFF. The next frame emits 8000 (MSB 1, then 15 zeros).
4. Reset -> pa_en=0 until the first 63 -> 0 wrap, which happens 512 clk after the first bit_idx 0. pa_en is then 1 and stays high.
5. rst asserted at bit_idx=20 for 1 cycle -> next cycle bclk=lrclk=sdata=pa_en=0. Restart behaves as in scenario 4.
6. half_period=1, sound=16'h0001 -> bclk=clk/2. sdata is high only at s=16 of each slot, and no bit slips over 3 consecutive frames.
